pwm_thresh_cmp: RTL
===================

PWM_THRESH_CMP -- requirements
Module: pwm_thresh_cmp

Interface
REQ-001 SHALL have parameter NCH, default 5, number of comparator channels.
REQ-002 SHALL have parameter DW, default 8, sample and threshold width.
REQ-003 SHALL have parameter CW, default 10, duty counter width; CW >= DW is required.
REQ-004 SHALL have parameter VIL_INIT, default 8'h55, post-reset low threshold.
REQ-005 SHALL have parameter VIH_INIT, default 8'hAA, post-reset high threshold.
REQ-006 SHALL have port clk, input, 1, the only clock; the block SHALL use one clock.
REQ-007 SHALL have port rst_n, input, 1, reset; reset SHALL be asynchronous and active-low.
REQ-008 SHALL have port VIL_PWM, input, 1, asynchronous PWM whose duty encodes VIL.
REQ-009 SHALL have port VIH_PWM, input, 1, asynchronous PWM whose duty encodes VIH.
REQ-010 SHALL have port smpl_vld, input, 1, qualifies smpl.
REQ-011 SHALL have port smpl, input, NCH*DW, packed samples; channel k occupies bits [k*DW +: DW].
REQ-012 SHALL have port chL, output, NCH, per-channel "not below VIL" flags.
REQ-013 SHALL have port chH, output, NCH, per-channel "above VIH" flags.
REQ-014 SHALL have port out_vld, output, 1, pulses when chL/chH update.
REQ-015 SHALL have ports VIL and VIH, output, DW each, current thresholds.
REQ-016 SHALL have port thr_upd, output, 2, one-cycle pulse per threshold capture; bit0 = VIL, bit1 = VIH.
REQ-017 SHALL have port thr_err, output, 1, high whenever VIL >= VIH.

Function
REQ-018 Each PWM input SHALL pass through a 2-flop synchronizer followed by a previous-value flop for edge detection.
REQ-019 Rise = synced high and previous low; fall = synced low and previous high.
REQ-020 Each PWM channel SHALL have states IDLE and ARMED; reset state is IDLE.
REQ-021 IDLE -> ARMED on the first rise; ARMED SHALL be held until reset.
REQ-022 A fall seen in IDLE SHALL be ignored: no capture and no thr_upd.
REQ-023 In ARMED, the CW-bit counter SHALL load 1 on a rise.
REQ-024 In ARMED, the counter SHALL increment by 1 on each synced-high non-rise cycle and SHALL saturate at all-ones with no wrap.
REQ-025 In ARMED, a fall SHALL load the threshold register with counter[CW-1 -: DW] and pulse the matching thr_upd bit for exactly one cycle.
REQ-026 The new threshold SHALL be visible on VIL/VIH the cycle after the fall is detected.
REQ-027 chL[k] SHALL be (sample_k >= VIL), unsigned.
REQ-028 chH[k] SHALL be (sample_k > VIH), unsigned.
REQ-029 chL, chH and out_vld SHALL be registered: out_vld is high in the cycle after smpl_vld, with one cycle of latency.
REQ-030 chL and chH SHALL hold their values when smpl_vld is low.
REQ-031 When smpl_vld coincides with a threshold capture, the compare SHALL use the pre-capture threshold.
REQ-032 thr_err SHALL be combinational from the VIL and VIH registers.
REQ-033 No compare gating SHALL depend on thr_err.

Reset
REQ-034 While rst_n is low, the block SHALL drive VIL = VIL_INIT, VIH = VIH_INIT, chL = 0, chH = 0, out_vld = 0, thr_upd = 0.
REQ-035 While rst_n is low, both FSMs SHALL be IDLE and all counters and synchronizer flops SHALL be 0.
REQ-036 Reset asserted mid-measurement SHALL discard the partial count.
REQ-037 After reset release, the block SHALL require a fresh rise before any capture.

Structure
REQ-038 Default parameter values and the IDLE/ARMED state enum SHALL live in a shared package, pwm_thresh_pkg.
REQ-039 The sync, edge, FSM, counter and capture path SHALL be one sub-module, pwm_duty_meas, instantiated twice.
REQ-040 The comparator array SHALL be a generate loop over NCH.

Verification
REQ-041 Reset with no PWM activity, smpl_vld pulse with all channels 8'h55 -> chL = all-ones, chH = 0, VIL = 8'h55, VIH = 8'hAA, thr_err = 0.
REQ-042 Low VIL_PWM, then high 512 cycles, then low -> VIL = 8'h80 and one thr_upd[0] pulse.
REQ-043 Low VIL_PWM, then high 256 cycles, then low -> VIL = 8'h40, thr_err = 0.
REQ-044 VIH_PWM high 1200 cycles -> counter saturates and VIH = 8'hFF.
REQ-045 VIH_PWM starting high out of reset, then falling -> VIH stays 8'hAA and no thr_upd[1].
REQ-046 VIL_PWM high 700 cycles -> VIL = 8'hAF > VIH = 8'hAA, so thr_err = 1.
REQ-047 After setting VIL = 8'h40 and VIH = 8'h80 by PWM, sample 8'h80 -> chL = 1, chH = 0.
REQ-048 With VIL = 8'h40 and VIH = 8'h80, sample 8'h3F -> chL = 0.
REQ-049 Reset mid-pulse, then a complete 512-cycle pulse -> VIL = 8'h80 with no carry-over from the partial count.

Source files
------------

// File: rtl/pwm_thresh_pkg.sv
// Shared defaults and state encoding for the PWM-programmed threshold comparator.
package pwm_thresh_pkg;

    localparam int unsigned NCH_DFLT = 5;
    localparam int unsigned DW_DFLT  = 8;
    localparam int unsigned CW_DFLT  = 10;

    localparam logic [7:0] VIL_INIT_DFLT = 8'h55;
    localparam logic [7:0] VIH_INIT_DFLT = 8'hAA;

    // Cycles after reset release before the synchronizer/previous-value
    // flops hold real samples of the PWM pin rather than reset zeros.
    localparam int unsigned SYNC_WARMUP = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } meas_state_e;

endpackage

// File: rtl/pwm_duty_meas.sv
// Measures the high time of an asynchronous PWM input and captures it as a
// DW-bit threshold (top DW bits of a saturating CW-bit high-time counter).
//   clk, rst_n : clock, async active-low reset
//   pwm_in     : asynchronous PWM input
//   thr        : captured threshold (THR_INIT after reset)
//   upd        : one-cycle pulse when thr has just been reloaded
module pwm_duty_meas
    import pwm_thresh_pkg::*;
#(
    parameter int unsigned    DW       = DW_DFLT,
    parameter int unsigned    CW       = CW_DFLT,
    parameter logic [DW-1:0]  THR_INIT = DW'(VIL_INIT_DFLT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [DW-1:0] thr,
    output logic          upd
);

    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   prev_q,  prev_d;
    logic [SYNC_WARMUP-1:0] warm_q,  warm_d;
    meas_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q,   cnt_d;
    logic [DW-1:0]          thr_q,   thr_d;
    logic                   upd_q,   upd_d;
    logic                   rise;
    logic                   fall;

    // Next-state: synchronizer, edge detect, arm FSM, duty counter, capture.
    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        warm_d  = {warm_q[SYNC_WARMUP-2:0], 1'b1};
        state_d = state_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        upd_d   = 1'b0;

        // Edges are only trusted once the flop chain holds real samples, so a
        // pin already high at reset release is not mistaken for a rise.
        rise = warm_q[SYNC_WARMUP-1] & sync2_q & ~prev_q;
        fall = warm_q[SYNC_WARMUP-1] & ~sync2_q & prev_q;

        case (state_q)
            IDLE: begin
                // The arming rise also starts the first measurement.
                if (rise) begin
                    state_d = ARMED;
                    cnt_d   = CW'(1);
                end
            end
            ARMED: begin
                if (rise) begin
                    cnt_d = CW'(1);
                end else if (sync2_q && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (fall) begin
                    thr_d = cnt_q[CW-1 -: DW];
                    upd_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            warm_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            thr_q   <= THR_INIT;
            upd_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            warm_q  <= warm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            upd_q   <= upd_d;
        end
    end

    assign thr = thr_q;
    assign upd = upd_q;

endmodule

// File: rtl/pwm_thresh_cmp.sv
// Multi-channel window comparator whose low/high thresholds are programmed by
// the duty of two asynchronous PWM inputs.
//   clk, rst_n       : clock, async active-low reset
//   VIL_PWM, VIH_PWM : asynchronous PWM inputs encoding VIL / VIH
//   smpl_vld, smpl   : packed samples, channel k at [k*DW +: DW]
//   chL, chH         : registered per-channel (>= VIL) / (> VIH) flags
//   out_vld          : pulses the cycle chL/chH update
//   VIL, VIH         : current thresholds
//   thr_upd          : capture pulses, bit0 = VIL, bit1 = VIH
//   thr_err          : combinational, high while VIL >= VIH
module pwm_thresh_cmp
    import pwm_thresh_pkg::*;
#(
    parameter int unsigned   NCH      = NCH_DFLT,
    parameter int unsigned   DW       = DW_DFLT,
    parameter int unsigned   CW       = CW_DFLT,
    parameter logic [DW-1:0] VIL_INIT = DW'(VIL_INIT_DFLT),
    parameter logic [DW-1:0] VIH_INIT = DW'(VIH_INIT_DFLT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              VIL_PWM,
    input  logic              VIH_PWM,
    input  logic              smpl_vld,
    input  logic [NCH*DW-1:0] smpl,
    output logic [NCH-1:0]    chL,
    output logic [NCH-1:0]    chH,
    output logic              out_vld,
    output logic [DW-1:0]     VIL,
    output logic [DW-1:0]     VIH,
    output logic [1:0]        thr_upd,
    output logic              thr_err
);

    logic           upd_l;
    logic           upd_h;
    logic [NCH-1:0] ge_vil;
    logic [NCH-1:0] gt_vih;
    logic [NCH-1:0] chl_q, chl_d;
    logic [NCH-1:0] chh_q, chh_d;
    logic           out_vld_q, out_vld_d;

    pwm_duty_meas #(
        .DW       (DW),
        .CW       (CW),
        .THR_INIT (VIL_INIT)
    ) u_meas_vil (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (VIL_PWM),
        .thr    (VIL),
        .upd    (upd_l)
    );

    pwm_duty_meas #(
        .DW       (DW),
        .CW       (CW),
        .THR_INIT (VIH_INIT)
    ) u_meas_vih (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (VIH_PWM),
        .thr    (VIH),
        .upd    (upd_h)
    );

    // Per-channel compares against the threshold registers as they stand this
    // cycle, so a coincident capture only affects later samples.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign ge_vil[k] = (smpl[k*DW +: DW] >= VIL);
        assign gt_vih[k] = (smpl[k*DW +: DW] >  VIH);
    end

    // Flags load on a valid sample and hold otherwise.
    always_comb begin
        chl_d     = chl_q;
        chh_d     = chh_q;
        out_vld_d = smpl_vld;
        if (smpl_vld) begin
            chl_d = ge_vil;
            chh_d = gt_vih;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chl_q     <= '0;
            chh_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            chl_q     <= chl_d;
            chh_q     <= chh_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign chL     = chl_q;
    assign chH     = chh_q;
    assign out_vld = out_vld_q;
    assign thr_upd = {upd_h, upd_l};
    assign thr_err = (VIL >= VIH);

endmodule
